// File: rtl/hamming_decoder.sv
// Streaming Hamming(7,4) decoder: syndrome stage, correction stage, and a
// saturating count of corrected words delivered downstream.
module hamming_decoder #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       code_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       data_out,
  output logic             corrected,
  output logic [2:0]       err_pos,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] corr_count
);

  localparam int unsigned CODE_W = 7;
  localparam int unsigned SYN_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              rdy_en;
  logic              s1_valid;
  logic [CODE_W-1:0] s1_code;
  logic [SYN_W-1:0]  s1_syn;
  logic [SYN_W-1:0]  syn_c;
  logic [CODE_W-1:0] fixed_c;
  logic              adv_c;
  logic              s1_load_c;
  logic              cnt_inc_c;

  // Syndrome bit i checks every position whose index has bit i set.
  assign syn_c = {code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6],
                  code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6],
                  code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6]};

  assign adv_c     = !out_valid || out_ready;
  assign s1_load_c = !s1_valid || adv_c;
  // rdy_en keeps in_ready low during reset and until the first clock after release.
  assign in_ready  = rdy_en && s1_load_c;
  assign cnt_inc_c = out_valid && out_ready && corrected && (corr_count != CNT_MAX);

  // Invert the bit at position syn (bit index syn-1); syn==0 leaves the word untouched.
  always_comb begin
    fixed_c = s1_code;
    for (int k = 0; k < int'(CODE_W); k++) begin
      if (s1_syn == SYN_W'(k + 1)) fixed_c[k] = ~s1_code[k];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdy_en <= 1'b0;
    else        rdy_en <= 1'b1;
  end

  // Stage 1: capture codeword and its syndrome.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_code  <= '0;
      s1_syn   <= '0;
    end else if (s1_load_c) begin
      s1_valid <= in_valid && rdy_en;
      if (in_valid && rdy_en) begin
        s1_code <= code_in;
        s1_syn  <= syn_c;
      end
    end
  end

  // Stage 2: corrected data; outputs hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      data_out  <= '0;
      corrected <= 1'b0;
      err_pos   <= '0;
    end else if (adv_c) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out  <= {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
        corrected <= (s1_syn != '0);
        err_pos   <= s1_syn;
      end
    end
  end

  // Saturating correction counter; a clear takes priority over an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         corr_count <= '0;
    else if (clr_cnt)   corr_count <= '0;
    else if (cnt_inc_c) corr_count <= corr_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed bench for hamming_decoder: scoreboard of expected words plus a
// per-cycle counter model; a narrow-counter instance shares the stimulus.
module tb_hamming_decoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [6:0]  code_in;
  logic        out_ready;
  logic        clr_cnt;
  logic        in_ready,  in_ready2;
  logic        out_valid, out_valid2;
  logic [3:0]  data_out,  data_out2;
  logic        corrected, corrected2;
  logic [2:0]  err_pos,   err_pos2;
  logic [15:0] corr_count;
  logic [1:0]  corr_count2;

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic [2:0] p;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mcnt   = 0;
  int   mcnt2  = 0;

  always #5 clk = ~clk;

  hamming_decoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .code_in(code_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .corrected(corrected), .err_pos(err_pos),
    .clr_cnt(clr_cnt), .corr_count(corr_count));

  hamming_decoder #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .code_in(code_in), .out_valid(out_valid2), .out_ready(out_ready),
    .data_out(data_out2), .corrected(corrected2), .err_pos(err_pos2),
    .clr_cnt(clr_cnt), .corr_count(corr_count2));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic p1, p2, p4;
    p1 = d[0] ^ d[1] ^ d[3];
    p2 = d[0] ^ d[2] ^ d[3];
    p4 = d[1] ^ d[2] ^ d[3];
    return {d[3], d[2], d[1], p4, d[0], p2, p1};
  endfunction

  // Offer a word; push its expectation at the cycle it is accepted.
  task automatic send(input logic [6:0] code, input logic [3:0] d,
                      input logic c, input logic [2:0] p);
    bit done = 1'b0;
    in_valid = 1'b1;
    code_in  = code;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{d: d, c: c, p: p});
        done = 1'b1;
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_left", sb.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  // Output monitor: pops on each output transfer and tracks both counters.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      mcnt  = 0;
      mcnt2 = 0;
    end else begin
      chk("corr_count", 32'(corr_count), mcnt);
      chk("corr_count_w2", 32'(corr_count2), mcnt2);
      chk("out_valid_w2", 32'(out_valid2), 32'(out_valid));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("spurious_out", 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk("data_out",  32'(data_out),  32'(e.d));
          chk("corrected", 32'(corrected), 32'(e.c));
          chk("err_pos",   32'(err_pos),   32'(e.p));
          chk("data_out_w2", 32'(data_out2), 32'(e.d));
          if (!clr_cnt && e.c) begin
            if (mcnt < 65535) mcnt++;
            if (mcnt2 < 3) mcnt2++;
          end
        end
      end
      if (clr_cnt) begin
        mcnt  = 0;
        mcnt2 = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] a;
    logic [6:0] w[4];
    logic [3:0] held;
    a = 7'b1010101;
    for (int i = 0; i < 4; i++) w[i] = encode(4'(3 * (i + 1)));

    rst_n = 1'b0; in_valid = 1'b0; code_in = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_data_out", 32'(data_out), 32'd0);
    chk("rst_err_pos", 32'(err_pos), 32'd0);
    chk("rst_corr_count", 32'(corr_count), 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("in_ready_pre_clk", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    chk("in_ready_post_clk", 32'(in_ready), 32'd1);

    // Zero codeword and two-cycle latency.
    send(7'b0000000, 4'b0000, 1'b0, 3'd0);
    chk("latency_s1", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("latency_s2", 32'(out_valid), 32'd1);
    drain();

    // Back-to-back clean words on consecutive cycles.
    send(a, 4'b1011, 1'b0, 3'd0);
    send(7'b1111111, 4'b1111, 1'b0, 3'd0);
    @(negedge clk);
    chk("b2b_first_valid", 32'(out_valid), 32'd1);
    chk("b2b_first_data", 32'(data_out), 32'hb);
    @(negedge clk);
    chk("b2b_second_valid", 32'(out_valid), 32'd1);
    chk("b2b_second_data", 32'(data_out), 32'hf);
    @(posedge clk); #1;
    drain();

    // Every single-bit flip corrects back to 1011.
    for (int k = 0; k < 7; k++) begin
      logic [6:0] flip;
      flip = 7'(1) << k;
      send(a ^ flip, 4'b1011, 1'b1, 3'(k + 1));
    end
    drain();
    chk("count_after_singles", 32'(corr_count), 32'd7);
    chk("count_w2_saturated", 32'(corr_count2), 32'd3);

    // Backpressure: two words buffered, then in_ready drops.
    out_ready = 1'b0;
    in_valid = 1'b1; code_in = w[0];
    @(negedge clk);
    chk("bp_accept0", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back('{d: 4'd3, c: 1'b0, p: 3'd0});
    @(posedge clk); #1;
    code_in = w[1];
    @(negedge clk);
    chk("bp_accept1", 32'(in_ready), 32'd1);
    if (in_ready) sb.push_back('{d: 4'd6, c: 1'b0, p: 3'd0});
    @(posedge clk); #1;
    code_in = w[2];
    @(negedge clk);
    held = data_out;
    chk("bp_head_data", 32'(held), 32'd3);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready_low", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_data_stable", 32'(data_out), 32'(held));
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(w[2], 4'd9, 1'b0, 3'd0);
    send(w[3], 4'd12, 1'b0, 3'd0);
    drain();

    // Double error miscorrects as the syndrome dictates.
    send(7'b1010110, 4'b1010, 1'b1, 3'd3);
    drain();
    chk("count_after_double", 32'(corr_count), 32'd8);

    // Clear coinciding with a corrected transfer wins.
    send(a ^ 7'b0000001, 4'b1011, 1'b1, 3'd1);
    @(posedge clk); #1;
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_wins", 32'(corr_count), 32'd0);
    chk("clr_wins_w2", 32'(corr_count2), 32'd0);
    chk("clr_sb_empty", sb.size(), 32'd0);

    // Mid-stream reset discards in-flight words.
    send(w[0], 4'd3, 1'b0, 3'd0);
    send(w[1], 4'd6, 1'b0, 3'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("midrst_in_ready_pre_clk", 32'(in_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("midrst_no_stale", 32'(out_valid), 32'd0);
    end
    send(a ^ 7'b1000000, 4'b1011, 1'b1, 3'd7);
    drain();
    chk("post_rst_count", 32'(corr_count), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hamming_decoder.md
Name: hamming_decoder

Overview:
Streaming Hamming(7,4) decoder with single-error correction. It is the receive-side counterpart of the hammingcode encoder. It accepts 7-bit codewords over a valid/ready handshake and computes the syndrome. It flips the erroneous bit, emits the 4 corrected data bits through a 2-stage pipeline, and keeps a saturating count of corrections for status/debug.

Parameters:
CNT_W, 16, width of the saturating correction counter corr_count (legal range 1..32).

Ports:
clk  input  1  single clock; all flops rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  code_in is valid this cycle.
in_ready  output  1  decoder can accept code_in this cycle.
code_in  input  7  codeword; bit k-1 = Hamming position k: [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3.
out_valid  output  1  data_out/corrected/err_pos valid.
out_ready  input  1  downstream accepts output this cycle.
data_out  output  4  corrected data {d3,d2,d1,d0}.
corrected  output  1  1 when syndrome was nonzero and a bit was flipped.
err_pos  output  3  syndrome = flipped position 1..7; 0 when no error.
clr_cnt  input  1  synchronous clear pulse for corr_count.
corr_count  output  CNT_W  number of corrected words delivered, saturating.

Behaviour:
- Reset (rst_n=0, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, data_out=0, corrected=0, err_pos=0, corr_count=0.
- While in reset, in_ready=0. After release, in_ready=1 on the first clock.
- Reset asserted mid-transfer discards all in-flight words with no output.
- Encoder relations: p1=d0^d1^d3; p2=d0^d2^d3; p4=d1^d2^d3.
- Syndrome: s1=c[0]^c[2]^c[4]^c[6]; s2=c[1]^c[2]^c[5]^c[6]; s4=c[3]^c[4]^c[5]^c[6]; syn={s4,s2,s1}.
- Stage 1: on a transfer (in_valid&in_ready), register code_in and syn; set s1_valid.
- Stage 2: when stage 1 advances, register the corrected word and set s2_valid.
  - If syn!=0, the corrected word is code with bit syn-1 inverted; otherwise it is unchanged.
  - data_out={c[6],c[5],c[4],c[2]}; corrected=(syn!=0); err_pos=syn.
- out_valid=s2_valid. Outputs are driven from stage-2 flops only.
- Advance rules:
  - stage 2 loads when !s2_valid | out_ready.
  - stage 1 advances into stage 2 under the same condition.
  - in_ready = !s1_valid | (!s2_valid | out_ready). Combinational from out_ready; no combinational path from in_valid.
- s1_valid/s2_valid clear when a stage empties without a refill.
- Latency: 2 cycles from input transfer to out_valid when unstalled. Throughput 1 word/cycle; no bubbles under continuous valid/ready.
- Backpressure:
  - With out_ready=0, stage 2 holds and stage 1 fills; in_ready then drops.
  - Outputs stay stable while out_valid&!out_ready.
  - Exactly 2 words are buffered. No word is lost or duplicated.
- Counter:
  - corr_count increments on each output transfer (out_valid&out_ready) with corrected=1.
  - It saturates at 2^CNT_W-1 and never wraps.
  - If clr_cnt and an increment occur in the same cycle, the clear wins (result 0).
- Double-bit errors are not detected: the decoder miscorrects per the syndrome. This is accepted (7,4) behaviour.

Test Plan:
1. Reset then code_in=7'b0000000 with out_ready=1 -> out_valid=1 two cycles later; data_out=4'b0000, corrected=0, err_pos=0, corr_count=0.
2. code_in=7'b1010101 (data 1011), then 7'b1111111 back-to-back -> data_out 4'b1011 then 4'b1111 on consecutive cycles, corrected=0.
3. Single errors: each of the 7 single-bit flips of 7'b1010101 (e.g. 7'b1000101) -> data_out=4'b1011, corrected=1, err_pos=1..7 matching the flipped position; corr_count=7 afterwards.
4. Backpressure: out_ready=0 while 4 words are offered -> in_ready drops after 2 accepted. Raising out_ready drains the words in order with no loss or duplication, then accepts the remaining 2.
5. Double error 7'b1010110 -> err_pos=3, corrected=1, data_out=4'b1010 (documented miscorrection).
6. CNT_W=2: 5 corrected words -> corr_count=3 (saturated). clr_cnt asserted in the same cycle as a 6th corrected transfer -> corr_count=0. Assert rst_n=0 mid-stream -> out_valid=0 immediately, and no stale output after release.
